bus_protocol_target: RTL and testbench

Receiving end (target) of the dValid/dAck byte-transfer bus. It detects a transfer start, returns a single-cycle dAck a programmable number of clocks after dValid rises, and captures the byte. Captured bytes are buffered in a small FIFO and presented on a valid/ready stream to the downstream consumer. It also flags master-side protocol violations; the flags are sticky until cleared.

---
 rtl/bus_protocol_target.sv | 96 +++++++++
 tb/tb_bus_protocol_target.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bus_protocol_target.sv
// bus_protocol_target: dValid/dAck bus target with a delayed single-cycle ack, a capture FIFO,
// a valid/ready output stream and sticky protocol-violation flags.
module bus_protocol_target #(
   parameter int ACK_DELAY  = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dValid,
   input  logic [7:0] data,
   output logic       dAck,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       overflow,
   output logic       proto_err,
   output logic [7:0] drop_cnt,
   input  logic       err_clr
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [1:0] CNT0 = 2'(ACK_DELAY > 1 ? ACK_DELAY - 2 : 0);
   if (ACK_DELAY < 1 || ACK_DELAY > 3) begin : g_bad_delay
      $error("ACK_DELAY must be 1..3");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two >= 2");
   end
   typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;
   state_t      state;
   logic        dv_q;
   logic [1:0]  cnt;
   logic [7:0]  shadow;
   logic [7:0]  last;
   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wptr, rptr;
   logic        start, empty, full, pop, capture, push, drop, in_xfer, perr_set;
   assign start    = dValid && !dv_q;
   assign empty    = wptr == rptr;
   assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop      = rx_valid && rx_ready;
   assign capture  = state == ACK && dValid;
   assign push     = capture && (!full || pop);
   assign drop     = capture && full && !pop;
   assign in_xfer  = state == WAIT || state == ACK;
   assign perr_set = (in_xfer && (data != shadow || !dValid)) || (state == DONE && dValid);
   assign rx_valid = !empty;
   assign rx_data  = empty ? last : mem[rptr[AW-1:0]];
   // dAck is raised one edge early so the registered pulse is seen at T+ACK_DELAY
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         dAck   <= 1'b0;
         dv_q   <= 1'b1;
         cnt    <= 2'd0;
         shadow <= 8'd0;
      end else begin
         dv_q <= dValid;
         case (state)
            IDLE: if (start) begin
               shadow <= data;
               cnt    <= CNT0;
               state  <= (ACK_DELAY == 1) ? ACK : WAIT;
               dAck   <= ACK_DELAY == 1;
            end
            WAIT: if (!dValid) state <= IDLE;
                  else if (cnt == 2'd0) begin
                     state <= ACK;
                     dAck  <= 1'b1;
                  end else cnt <= cnt - 2'd1;
            ACK: begin
               dAck  <= 1'b0;
               state <= dValid ? DONE : IDLE;
            end
            DONE: if (!dValid) state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) if (push) mem[wptr[AW-1:0]] <= data;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr      <= '0;
         rptr      <= '0;
         last      <= 8'd0;
         overflow  <= 1'b0;
         proto_err <= 1'b0;
         drop_cnt  <= 8'd0;
      end else begin
         wptr      <= push ? wptr + 1'b1 : wptr;
         rptr      <= pop ? rptr + 1'b1 : rptr;
         last      <= pop ? mem[rptr[AW-1:0]] : last;
         overflow  <= err_clr ? 1'b0 : overflow | drop;
         proto_err <= err_clr ? 1'b0 : proto_err | perr_set;
         drop_cnt  <= err_clr ? 8'd0 : (drop && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
      end
   end
endmodule

// File: tb/tb_bus_protocol_target.sv
// tb_bus_protocol_target: scoreboard bench; instance k runs with ACK_DELAY=k+1 and queues
// hold the expected dAck cycle and the expected captured bytes for each instance.
module tb_bus_protocol_target;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       err_clr = 1'b0;
   logic       dv [3];
   logic [7:0] dt [3];
   logic       rx_ready [3];
   logic       dack [3];
   logic [7:0] rx_data [3];
   logic       rx_valid [3];
   logic       overflow [3];
   logic       proto_err [3];
   logic [7:0] drop_cnt [3];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         ackq [3][$];
   logic [7:0] rxq [3][$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      bus_protocol_target #(.ACK_DELAY(g + 1), .FIFO_DEPTH(4)) u_dut (
         .clk(clk), .reset(reset), .dValid(dv[g]), .data(dt[g]), .dAck(dack[g]),
         .rx_data(rx_data[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
         .overflow(overflow[g]), .proto_err(proto_err[g]), .drop_cnt(drop_cnt[g]),
         .err_clr(err_clr));
   end
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         int         e;
         logic [7:0] eb;
         if (dack[k]) begin
            checks++;
            if (ackq[k].size() == 0) begin
               errors++;
               $display("FAIL dack%0d unexpected at cycle %0d", k, cyc);
            end else begin
               e = ackq[k].pop_front();
               if (e != cyc) begin
                  errors++;
                  $display("FAIL dack%0d timing: seen at cycle %0d, expected %0d", k, cyc, e);
               end
            end
         end
         if (rx_valid[k] && rx_ready[k]) begin
            checks++;
            if (rxq[k].size() == 0) begin
               errors++;
               $display("FAIL rx%0d unexpected byte %h", k, rx_data[k]);
            end else begin
               eb = rxq[k].pop_front();
               if (eb != rx_data[k]) begin
                  errors++;
                  $display("FAIL rx%0d data: got %h, expected %h", k, rx_data[k], eb);
               end
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   task automatic xfer(input int k, input logic [7:0] b, input logic [7:0] b2,
                       input bit keep, input bit pop, input bit hold);
      dv[k] = 1'b1;
      dt[k] = b;
      ackq[k].push_back(cyc + k + 1);
      if (keep) rxq[k].push_back(b2);
      tick();
      dt[k] = b2;
      repeat (k) tick();
      if (pop) rx_ready[k] = 1'b1;
      tick();
      if (pop) rx_ready[k] = 1'b0;
      if (hold) tick();
      dv[k] = 1'b0;
      tick();
   endtask
   initial begin
      for (int k = 0; k < 3; k++) begin
         dv[k] = 1'b0;
         dt[k] = 8'h00;
         rx_ready[k] = 1'b1;
      end
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset dAck%0d", k), int'(dack[k]), 0);
         chk($sformatf("reset rx_valid%0d", k), int'(rx_valid[k]), 0);
         chk($sformatf("reset rx_data%0d", k), int'(rx_data[k]), 0);
         chk($sformatf("reset overflow%0d", k), int'(overflow[k]), 0);
         chk($sformatf("reset proto_err%0d", k), int'(proto_err[k]), 0);
         chk($sformatf("reset drop_cnt%0d", k), int'(drop_cnt[k]), 0);
      end
      reset = 1'b1;
      repeat (2) tick();
      xfer(1, 8'hA5, 8'hA5, 1, 0, 0);
      chk("clean xfer proto_err", int'(proto_err[1]), 0);
      xfer(0, 8'h3C, 8'h3C, 1, 0, 0);
      xfer(2, 8'h3C, 8'h3C, 1, 0, 0);
      chk("delay1 proto_err", int'(proto_err[0]), 0);
      chk("delay3 proto_err", int'(proto_err[2]), 0);
      rx_ready[1] = 1'b0;
      for (int i = 1; i <= 5; i++) xfer(1, 8'(i), 8'(i), i < 5, 0, 0);
      chk("overflow set", int'(overflow[1]), 1);
      chk("drop_cnt one", int'(drop_cnt[1]), 1);
      chk("full rx_valid", int'(rx_valid[1]), 1);
      xfer(1, 8'h06, 8'h06, 1, 1, 0);
      chk("pop on full drop_cnt", int'(drop_cnt[1]), 1);
      rx_ready[1] = 1'b1;
      repeat (6) tick();
      chk("drained rx_valid", int'(rx_valid[1]), 0);
      chk("drained rx_data holds", int'(rx_data[1]), 8'h06);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr overflow", int'(overflow[1]), 0);
      chk("clr drop_cnt", int'(drop_cnt[1]), 0);
      xfer(1, 8'h11, 8'h22, 1, 0, 0);
      chk("data change proto_err", int'(proto_err[1]), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr proto_err", int'(proto_err[1]), 0);
      xfer(1, 8'h77, 8'h77, 1, 0, 1);
      chk("hold proto_err", int'(proto_err[1]), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr proto_err after hold", int'(proto_err[1]), 0);
      dv[2] = 1'b1;
      dt[2] = 8'h99;
      tick();
      dv[2] = 1'b0;
      repeat (4) tick();
      chk("abort proto_err", int'(proto_err[2]), 1);
      chk("abort no write", int'(rx_valid[2]), 0);
      dv[1] = 1'b1;
      dt[1] = 8'h5A;
      tick();
      reset = 1'b0;
      repeat (2) tick();
      chk("in reset dAck", int'(dack[1]), 0);
      reset = 1'b1;
      repeat (4) tick();
      chk("held dValid no start proto_err", int'(proto_err[1]), 0);
      chk("held dValid no capture", int'(rx_valid[1]), 0);
      dv[1] = 1'b0;
      tick();
      xfer(1, 8'hC3, 8'hC3, 1, 0, 0);
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("pending acks%0d", k), ackq[k].size(), 0);
         chk($sformatf("pending bytes%0d", k), rxq[k].size(), 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
